lookup_flowktb: RTL and testbench
=================================

Name: lookup_flowktb

Overview:
Downstream neighbour of the hash-table lookup stage in the UniMan connection searcher. Takes the candidate index (flowK_idx_valid/flowK_idx_info) and the matching 104-bit flow key, which it buffers from the same metadata stream. It reads the flow-key table, compares the stored key with the buffered key, and reports hit/miss with a connection index. On a miss it allocates a new index and writes both the flow-key table and the hash table.

Parameters:
w_key, 104, flow key width (metadata[103:0])
d_hashTb, 3, hash-table address width
w_idx, 16, index width; index 0 means "no entry"
d_flowKTb, 3, flow-key table address width; allocatable indices 1..2^d_flowKTb-1
d_fifo, 3, log2 depth of key FIFO (8 entries)
d_hist, 8, recent-insert history entries

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
metadata_in_valid  in  1  key enters FIFO (same strobe the hash stage sees)
metadata_in  in  w_key  flow key
flowK_idx_valid  in  1  candidate index valid (in metadata order)
flowK_idx_info  in  w_idx  candidate index, 0 = hash miss
flowKTb_rden  out  1  flow-key table read
flowKTb_rdaddr  out  d_flowKTb  read address
flowKTb_rdata  in  w_key  read data, fixed 2-cycle latency
flowKTb_wren  out  1  flow-key table write
flowKTb_wraddr  out  d_flowKTb  write address
flowKTb_wrdata  out  w_key  key written
hashTb_wren  out  1  hash-table write
hashTb_wraddr  out  d_hashTb  hash bucket
hashTb_wrdata  out  17  {valid=1, idx[15:0]}
result_valid  out  1  one-cycle result strobe
result_hit  out  1  1 = existing flow
result_idx  out  w_idx  connection index; 0 if table full
result_full  out  1  miss and no free index
err  out  1  sticky: FIFO overflow or pop-when-empty

Behaviour:
- Reset: all outputs 0, FIFO empty, history invalid, next_free=1.
- Key FIFO: push on metadata_in_valid. Push while full drops the key and sets err. Pop on flowK_idx_valid. Pop while empty sets err, and that candidate is ignored. A push and pop in the same cycle are both legal when full.
- Stage A (flowK_idx_valid cycle): pop the key. Assert rden with rdaddr=flowK_idx_info[d_flowKTb-1:0] only if idx != 0. Carry key, idx and hash down the pipe.
- Hash: key[2:0]^key[34:32]^key[66:64]^key[82:80].
- Stage A+2: rdata is valid. tbl_hit = (idx != 0) && (rdata == key).
- Stage A+3: registered result.
  - tbl_hit: result_hit=1, result_idx=idx.
  - Otherwise, if key matches a valid history entry: hit with the history idx, no write. This closes the window where an earlier insert has not yet reached the hash/key tables.
  - Otherwise, miss. If next_free != 0: one-cycle write of flowKTb[next_free]=key and hashTb[hash]={1,next_free} (a colliding slot is overwritten; the newest flow wins). Report result_idx=next_free and hit=0, push {key, next_free} into the history shift register, then next_free++.
  - next_free wraps from 2^d_flowKTb-1 to 0 and then stays 0 (table full). A miss while full gives result_full=1, result_idx=0 and no writes.
- One result per flowK_idx_valid, in order, latency 3 cycles, full throughput (back-to-back accepted).
- If history and table both match, the table wins. A history match takes the youngest matching entry.
- Reset mid-operation: pipeline, FIFO, history and allocator are cleared. No write strobe is asserted in the reset cycle or the one after.

Optional Feature:
LOOKUP_FLOWKTB_STATS_EN: adds outputs hit_cnt, miss_cnt and full_cnt (32-bit, saturating, cleared by reset), incremented on each result_valid by outcome. Without the macro, these ports and counters do not exist.

Decomposition:
- Shared package: w_key, w_idx, d_hashTb, the hash-field bit offsets (0/32/64/80/96), the hashTb entry layout (valid bit 16, idx 15:0), and the IDX_NONE=0 constant.
- One sub-module: lookup_flowktb_fifo (synchronous show-ahead key FIFO with full/empty).

Test Plan:
- New flow key K1 (idx_info=0) -> at A+3: result_hit=0, result_idx=1, flowKTb_wren to addr1 with K1, hashTb_wren bucket=hash(K1) data 0x10001.
- K1 again 20 cycles later, idx_info=1, rdata=K1 -> result_hit=1, idx=1, no writes.
- K1 sent on two consecutive cycles, both idx_info=0 -> first: miss/idx=1 with writes; second: hit via history, idx=1, no writes.
- Collision: idx_info=1, rdata=K1, key=K2 -> miss, idx=2, hashTb bucket overwritten with 0x10002.
- Eight distinct new flows -> indices 1..7, then the 8th gives result_full=1, result_idx=0, no writes.
- Nine metadata_in_valid pulses with no flowK_idx_valid -> err=1 and the 9th key is dropped. Reset mid-stream -> all outputs 0 and the next new flow gets idx=1.

Source files
------------

// File: rtl/lookup_flowktb_pkg.sv
// Shared types and constants for the flow-key table lookup stage.
package lookup_flowktb_pkg;

  localparam int W_KEY     = 104;
  localparam int W_IDX     = 16;
  localparam int D_HASHTB  = 3;
  localparam int D_FLOWKTB = 3;
  localparam int D_FIFO    = 3;
  localparam int D_HIST    = 8;

  // Bit offsets of the key fields; the bucket hash XORs the low
  // d_hashTb bits of the first four fields. HASH_OFF4 marks the top field (103:96).
  localparam int HASH_OFF0 = 0;
  localparam int HASH_OFF1 = 32;
  localparam int HASH_OFF2 = 64;
  localparam int HASH_OFF3 = 80;
  localparam int HASH_OFF4 = 96;

  // Hash-table entry layout: valid in bit 16, index in 15:0.
  localparam int HTB_VALID_BIT = 16;

  typedef struct packed {
    logic             valid;
    logic [W_IDX-1:0] idx;
  } htb_entry_t;

  localparam logic [W_IDX-1:0] IDX_NONE = '0;

  // Outcome of one lookup, decided in the cycle the table read data returns.
  typedef enum logic [1:0] {
    OUT_TBL_HIT  = 2'd0,
    OUT_HIST_HIT = 2'd1,
    OUT_NEW      = 2'd2,
    OUT_FULL     = 2'd3
  } outcome_e;

endpackage

// File: rtl/lookup_flowktb_fifo.sv
// Synchronous show-ahead key FIFO. head is valid whenever empty is low.
// A push while full is accepted only if a pop happens in the same cycle.
module lookup_flowktb_fifo #(
  parameter int w_data  = 104,
  parameter int d_depth = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [w_data-1:0] push_data,
  input  logic              pop,
  output logic [w_data-1:0] head,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  output logic              underflow
);

  localparam logic [d_depth:0] DEPTH = {1'b1, {d_depth{1'b0}}};

  logic [w_data-1:0]  mem [2**d_depth];
  logic [d_depth-1:0] wr_ptr;
  logic [d_depth-1:0] rd_ptr;
  logic [d_depth:0]   count;
  logic               do_push;
  logic               do_pop;

  // Qualify requests against occupancy and flag the illegal ones.
  always_comb begin
    full      = (count == DEPTH);
    empty     = (count == '0);
    do_pop    = pop & ~empty;
    do_push   = push & (~full | do_pop);
    overflow  = push & full & ~do_pop;
    underflow = pop & empty;
    head      = mem[rd_ptr];
  end

  // Storage array; contents are don't-care while empty so it is not reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/lookup_flowktb.sv
// Flow-key table lookup: verifies hash-stage candidates against the stored
// key, resolves in-flight inserts through a short history, and allocates
// new connection indices on a miss.
// Optional: define LOOKUP_FLOWKTB_STATS_EN for hit/miss/full counters.
module lookup_flowktb
  import lookup_flowktb_pkg::*;
#(
  parameter int w_key     = W_KEY,
  parameter int d_hashTb  = D_HASHTB,
  parameter int w_idx     = W_IDX,
  parameter int d_flowKTb = D_FLOWKTB,
  parameter int d_fifo    = D_FIFO,
  parameter int d_hist    = D_HIST
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 metadata_in_valid,
  input  logic [w_key-1:0]     metadata_in,
  input  logic                 flowK_idx_valid,
  input  logic [w_idx-1:0]     flowK_idx_info,
  output logic                 flowKTb_rden,
  output logic [d_flowKTb-1:0] flowKTb_rdaddr,
  input  logic [w_key-1:0]     flowKTb_rdata,
  output logic                 flowKTb_wren,
  output logic [d_flowKTb-1:0] flowKTb_wraddr,
  output logic [w_key-1:0]     flowKTb_wrdata,
  output logic                 hashTb_wren,
  output logic [d_hashTb-1:0]  hashTb_wraddr,
  output logic [HTB_VALID_BIT:0] hashTb_wrdata,
  output logic                 result_valid,
  output logic                 result_hit,
  output logic [w_idx-1:0]     result_idx,
  output logic                 result_full,
  output logic                 err
`ifdef LOOKUP_FLOWKTB_STATS_EN
  ,
  output logic [31:0]          hit_cnt,
  output logic [31:0]          miss_cnt,
  output logic [31:0]          full_cnt
`endif
);

  logic                 fifo_full, fifo_empty, fifo_ovf, fifo_udf;
  logic [w_key-1:0]     fifo_key;
  logic                 a_valid;
  logic [d_hashTb-1:0]  a_hash;

  logic                 s1_valid, s2_valid;
  logic [w_key-1:0]     s1_key, s2_key;
  logic [w_idx-1:0]     s1_idx, s2_idx;
  logic [d_hashTb-1:0]  s1_hash, s2_hash;

  logic [w_key-1:0]     hist_key [d_hist];
  logic [w_idx-1:0]     hist_idx [d_hist];
  logic [d_hist-1:0]    hist_vld;
  logic                 hist_hit;
  logic [w_idx-1:0]     hist_sel_idx;

  logic [d_flowKTb-1:0] next_free;
  logic [w_idx-1:0]     alloc_idx;
  logic                 tbl_hit;
  logic                 alloc;
  outcome_e             outcome;

  lookup_flowktb_fifo #(
    .w_data  (w_key),
    .d_depth (d_fifo)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (metadata_in_valid),
    .push_data (metadata_in),
    .pop       (flowK_idx_valid),
    .head      (fifo_key),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .overflow  (fifo_ovf),
    .underflow (fifo_udf)
  );

  // Stage A: candidate paired with its key; read the table only for real candidates.
  always_comb begin
    a_valid        = flowK_idx_valid & ~fifo_empty;
    a_hash         = fifo_key[HASH_OFF0 +: d_hashTb] ^ fifo_key[HASH_OFF1 +: d_hashTb]
                   ^ fifo_key[HASH_OFF2 +: d_hashTb] ^ fifo_key[HASH_OFF3 +: d_hashTb];
    flowKTb_rden   = a_valid && (flowK_idx_info != w_idx'(IDX_NONE));
    flowKTb_rdaddr = flowKTb_rden ? flowK_idx_info[d_flowKTb-1:0] : '0;
  end

  // Two pipeline stages covering the table read latency.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_key   <= '0;
      s1_idx   <= '0;
      s1_hash  <= '0;
      s2_valid <= 1'b0;
      s2_key   <= '0;
      s2_idx   <= '0;
      s2_hash  <= '0;
    end else begin
      s1_valid <= a_valid;
      s1_key   <= fifo_key;
      s1_idx   <= flowK_idx_info;
      s1_hash  <= a_hash;
      s2_valid <= s1_valid;
      s2_key   <= s1_key;
      s2_idx   <= s1_idx;
      s2_hash  <= s1_hash;
    end
  end

  // Decide the outcome: table match, then youngest history match, then allocate.
  always_comb begin
    hist_hit     = 1'b0;
    hist_sel_idx = '0;
    for (int unsigned i = 0; i < d_hist; i++) begin
      if (!hist_hit && hist_vld[i] && (hist_key[i] == s2_key)) begin
        hist_hit     = 1'b1;
        hist_sel_idx = hist_idx[i];
      end
    end
    tbl_hit   = (s2_idx != w_idx'(IDX_NONE)) && (flowKTb_rdata == s2_key);
    alloc_idx = w_idx'(next_free);
    if (tbl_hit)               outcome = OUT_TBL_HIT;
    else if (hist_hit)         outcome = OUT_HIST_HIT;
    else if (next_free != '0)  outcome = OUT_NEW;
    else                       outcome = OUT_FULL;
    alloc = s2_valid && (outcome == OUT_NEW);
  end

  // Registered result and table write strobes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result_valid   <= 1'b0;
      result_hit     <= 1'b0;
      result_idx     <= '0;
      result_full    <= 1'b0;
      flowKTb_wren   <= 1'b0;
      flowKTb_wraddr <= '0;
      flowKTb_wrdata <= '0;
      hashTb_wren    <= 1'b0;
      hashTb_wraddr  <= '0;
      hashTb_wrdata  <= '0;
    end else begin
      result_valid   <= s2_valid;
      result_hit     <= 1'b0;
      result_idx     <= '0;
      result_full    <= 1'b0;
      flowKTb_wren   <= 1'b0;
      flowKTb_wraddr <= '0;
      flowKTb_wrdata <= '0;
      hashTb_wren    <= 1'b0;
      hashTb_wraddr  <= '0;
      hashTb_wrdata  <= '0;
      if (s2_valid) begin
        case (outcome)
          OUT_TBL_HIT: begin
            result_hit <= 1'b1;
            result_idx <= s2_idx;
          end
          OUT_HIST_HIT: begin
            result_hit <= 1'b1;
            result_idx <= hist_sel_idx;
          end
          OUT_NEW: begin
            result_idx     <= alloc_idx;
            flowKTb_wren   <= 1'b1;
            flowKTb_wraddr <= next_free;
            flowKTb_wrdata <= s2_key;
            hashTb_wren    <= 1'b1;
            hashTb_wraddr  <= s2_hash;
            hashTb_wrdata  <= htb_entry_t'{valid: 1'b1, idx: W_IDX'(alloc_idx)};
          end
          default: result_full <= 1'b1;
        endcase
      end
    end
  end

  // Allocator and insert history; entry 0 is the youngest insert.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      next_free <= d_flowKTb'(1);
      hist_vld  <= '0;
      for (int unsigned i = 0; i < d_hist; i++) begin
        hist_key[i] <= '0;
        hist_idx[i] <= '0;
      end
    end else if (alloc) begin
      // Incrementing past the last index wraps to 0, which then blocks allocation.
      next_free   <= next_free + 1'b1;
      hist_vld    <= {hist_vld[d_hist-2:0], 1'b1};
      hist_key[0] <= s2_key;
      hist_idx[0] <= alloc_idx;
      for (int unsigned i = 1; i < d_hist; i++) begin
        hist_key[i] <= hist_key[i-1];
        hist_idx[i] <= hist_idx[i-1];
      end
    end
  end

  // Sticky error on key FIFO overflow or underflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                     err <= 1'b0;
    else if (fifo_ovf || fifo_udf)  err <= 1'b1;
  end

`ifdef LOOKUP_FLOWKTB_STATS_EN
  // Saturating outcome counters, bumped alongside each result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
      full_cnt <= '0;
    end else if (s2_valid) begin
      case (outcome)
        OUT_TBL_HIT, OUT_HIST_HIT: if (hit_cnt  != '1) hit_cnt  <= hit_cnt  + 1'b1;
        OUT_NEW:                   if (miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
        default:                   if (full_cnt != '1) full_cnt <= full_cnt + 1'b1;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_lookup_flowktb.sv
// Scoreboard bench for lookup_flowktb with a behavioural flow-key table (2-cycle read).
module tb_lookup_flowktb;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          metadata_in_valid = 1'b0;
  logic [103:0]  metadata_in = '0;
  logic          flowK_idx_valid = 1'b0;
  logic [15:0]   flowK_idx_info = '0;
  logic          flowKTb_rden;
  logic [2:0]    flowKTb_rdaddr;
  logic [103:0]  flowKTb_rdata;
  logic          flowKTb_wren;
  logic [2:0]    flowKTb_wraddr;
  logic [103:0]  flowKTb_wrdata;
  logic          hashTb_wren;
  logic [2:0]    hashTb_wraddr;
  logic [16:0]   hashTb_wrdata;
  logic          result_valid;
  logic          result_hit;
  logic [15:0]   result_idx;
  logic          result_full;
  logic          err;
`ifdef LOOKUP_FLOWKTB_STATS_EN
  logic [31:0]   hit_cnt, miss_cnt, full_cnt;
`endif

  lookup_flowktb dut (
    .clk               (clk),
    .reset             (reset),
    .metadata_in_valid (metadata_in_valid),
    .metadata_in       (metadata_in),
    .flowK_idx_valid   (flowK_idx_valid),
    .flowK_idx_info    (flowK_idx_info),
    .flowKTb_rden      (flowKTb_rden),
    .flowKTb_rdaddr    (flowKTb_rdaddr),
    .flowKTb_rdata     (flowKTb_rdata),
    .flowKTb_wren      (flowKTb_wren),
    .flowKTb_wraddr    (flowKTb_wraddr),
    .flowKTb_wrdata    (flowKTb_wrdata),
    .hashTb_wren       (hashTb_wren),
    .hashTb_wraddr     (hashTb_wraddr),
    .hashTb_wrdata     (hashTb_wrdata),
    .result_valid      (result_valid),
    .result_hit        (result_hit),
    .result_idx        (result_idx),
    .result_full       (result_full),
    .err               (err)
`ifdef LOOKUP_FLOWKTB_STATS_EN
    ,
    .hit_cnt           (hit_cnt),
    .miss_cnt          (miss_cnt),
    .full_cnt          (full_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // External flow-key table: registered read, one extra output register.
  logic [103:0] tbl [8] = '{default: '0};
  logic [103:0] rd_p1 = '0;
  initial flowKTb_rdata = '0;
  always @(posedge clk) begin
    if (flowKTb_wren) tbl[flowKTb_wraddr] <= flowKTb_wrdata;
    rd_p1         <= flowKTb_rden ? tbl[flowKTb_rdaddr] : '0;
    flowKTb_rdata <= rd_p1;
  end

  typedef struct {
    logic         hit;
    logic [15:0]  idx;
    logic         full;
    logic         fw;
    logic [2:0]   faddr;
    logic [103:0] fdata;
    logic         hw;
    logic [2:0]   haddr;
    logic [16:0]  hdata;
    int           cyc;
  } exp_t;

  exp_t         sb [$];
  logic [103:0] mkeys [$];
  logic [103:0] mtbl [8] = '{default: '0};
  logic [103:0] mhk [$];
  logic [15:0]  mhi [$];
  logic [2:0]   mnf = 3'd1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] thash(input logic [103:0] k);
    return k[2:0] ^ k[34:32] ^ k[66:64] ^ k[82:80];
  endfunction

  // Reference decision for one candidate; updates model table/history/allocator.
  function automatic exp_t predict(input logic [103:0] k, input logic [15:0] idx);
    exp_t e;
    int   hi;
    logic [2:0] ia;
    e = '{hit: 1'b0, idx: '0, full: 1'b0, fw: 1'b0, faddr: '0, fdata: '0,
          hw: 1'b0, haddr: '0, hdata: '0, cyc: 0};
    hi = -1;
    ia = idx[2:0];
    for (int i = 0; i < mhk.size(); i++)
      if (hi < 0 && mhk[i] == k) hi = i;
    if (idx != 16'd0 && mtbl[ia] == k) begin
      e.hit = 1'b1;
      e.idx = idx;
    end else if (hi >= 0) begin
      e.hit = 1'b1;
      e.idx = mhi[hi];
    end else if (mnf != 3'd0) begin
      e.idx   = {13'd0, mnf};
      e.fw    = 1'b1;
      e.faddr = mnf;
      e.fdata = k;
      e.hw    = 1'b1;
      e.haddr = thash(k);
      e.hdata = {1'b1, 13'd0, mnf};
      mtbl[mnf] = k;
      mhk.push_front(k);
      mhi.push_front({13'd0, mnf});
      if (mhk.size() > 8) begin
        void'(mhk.pop_back());
        void'(mhi.pop_back());
      end
      mnf = mnf + 3'd1;
    end else begin
      e.full = 1'b1;
    end
    return e;
  endfunction

  task automatic model_reset();
    sb.delete();
    mkeys.delete();
    mhk.delete();
    mhi.delete();
    mnf = 3'd1;
  endtask

  // One cycle of stimulus; candidates that find a key queue an expectation.
  task automatic drive(input bit do_push, input logic [103:0] key, input bit do_pop, input logic [15:0] idx);
    exp_t e;
    logic [103:0] pk;
    bit had;
    metadata_in_valid = do_push;
    metadata_in       = do_push ? key : '0;
    flowK_idx_valid   = do_pop;
    flowK_idx_info    = do_pop ? idx : '0;
    had = 1'b0;
    pk  = '0;
    if (do_pop && mkeys.size() > 0) begin
      pk  = mkeys.pop_front();
      had = 1'b1;
    end
    if (do_push && mkeys.size() < 8) mkeys.push_back(key);
    if (had) begin
      e = predict(pk, idx);
      e.cyc = cyc;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    metadata_in_valid = 1'b0;
    metadata_in       = '0;
    flowK_idx_valid   = 1'b0;
    flowK_idx_info    = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [103:0] nkey(input int i);
    return {8'hA5, 32'(i * 7 + 3), 32'(i ^ 32'h55), 32'(i + 17)};
  endfunction

  // Result monitor, sampling on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (result_valid) begin
      check("result_expected", 128'(sb.size() != 0), 128'(1));
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("latency",   128'(cyc - e.cyc), 128'(3));
        check("hit",       128'(result_hit),     128'(e.hit));
        check("idx",       128'(result_idx),     128'(e.idx));
        check("full",      128'(result_full),    128'(e.full));
        check("fk_wren",   128'(flowKTb_wren),   128'(e.fw));
        check("hb_wren",   128'(hashTb_wren),    128'(e.hw));
        if (e.fw) begin
          check("fk_wraddr", 128'(flowKTb_wraddr), 128'(e.faddr));
          check("fk_wrdata", 128'(flowKTb_wrdata), 128'(e.fdata));
          check("hb_wraddr", 128'(hashTb_wraddr),  128'(e.haddr));
          check("hb_wrdata", 128'(hashTb_wrdata),  128'(e.hdata));
        end
      end
    end else begin
      check("wr_idle", 128'({flowKTb_wren, hashTb_wren}), 128'(0));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [103:0] k1, k2, k3;
    int w;
    k1 = 104'h11_2222_3333_4444_5555_6666_7777;
    k2 = k1 ^ (104'h1 << 8);
    k3 = 104'h9A_BCDE_F012_3456_789A_BCDE_F013;
    model_reset();

    idle(3);
    check("rst_result_valid", 128'(result_valid), 128'(0));
    check("rst_result_idx",   128'(result_idx),   128'(0));
    check("rst_rden",         128'(flowKTb_rden), 128'(0));
    check("rst_wren",         128'({flowKTb_wren, hashTb_wren}), 128'(0));
    check("rst_err",          128'(err),          128'(0));
    reset = 1'b1;
    idle(1);

    // New flow, then the same flow confirmed through the table.
    drive(1, k1, 0, 16'd0);
    drive(0, '0, 1, 16'd0);
    idle(20);
    drive(1, k1, 0, 16'd0);
    drive(0, '0, 1, 16'd1);
    idle(6);

    // Same bucket, different key at candidate 1: allocates idx 2.
    drive(1, k2, 0, 16'd0);
    drive(0, '0, 1, 16'd1);
    idle(6);
    check("err_clean", 128'(err), 128'(0));

    // Reset while a lookup is in flight.
    drive(1, k3, 0, 16'd0);
    drive(0, '0, 1, 16'd0);
    idle(1);
    reset = 1'b0;
    model_reset();
    #1;
    check("midrst_result_valid", 128'(result_valid), 128'(0));
    check("midrst_wren", 128'({flowKTb_wren, hashTb_wren}), 128'(0));
    idle(2);
    reset = 1'b1;
    idle(1);

    // Back-to-back identical new flows: second resolves via history.
    drive(1, k1, 0, 16'd0);
    drive(1, k1, 0, 16'd0);
    drive(0, '0, 1, 16'd0);
    drive(0, '0, 1, 16'd0);
    idle(6);

    // Overflow the key FIFO, then exhaust the allocator.
    reset = 1'b0;
    model_reset();
    idle(1);
    reset = 1'b1;
    idle(1);
    for (int i = 0; i < 8; i++) drive(1, nkey(i), 0, 16'd0);
    check("err_at_full", 128'(err), 128'(0));
    drive(1, nkey(8), 0, 16'd0);
    check("err_overflow", 128'(err), 128'(1));
    for (int i = 0; i < 9; i++) drive(0, '0, 1, 16'd0);

    w = 0;
    while (sb.size() != 0 && w < 50) begin
      @(posedge clk);
      w++;
    end
    idle(4);
    check("drain", 128'(sb.size()), 128'(0));
    check("err_sticky", 128'(err), 128'(1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
